mem_stage_skid: RTL and testbench
=================================

# mem_stage_skid

Parametrised EX→MEM pipeline stage register with a valid/ready handshake and a two-entry skid buffer, so that back-pressure from the memory stage never creates a combinational path to the execute stage. The block carries the destination register, write data, byte enables and opcode. It adds a synchronous flush, forwarding outputs, and a saturating stall counter. It sits between the execute stage and the memory/writeback path.

## Interface
- `DATA_W`, default 32, width of the write data.
- `BE_W`, default `DATA_W/8`, width of the byte-enable field.
- `REG_W`, default 5, width of the register index.
- `OPC_W`, default 6, width of the opcode.
- `CNT_W`, default 16, width of the stall counter.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush.
- `in_valid`  in  1  upstream entry is valid.
- `in_ready`  out  1  stage can accept an entry; registered.
- `in_write_reg`  in  REG_W  destination register.
- `in_write_data`  in  DATA_W  write data.
- `in_byteenable`  in  BE_W  byte lanes.
- `in_opcode`  in  OPC_W  opcode.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  downstream accepts the head entry.
- `out_write_reg`, `out_write_data`, `out_byteenable`, `out_opcode`  out  REG_W/DATA_W/BE_W/OPC_W  head entry payload.
- `fwd_valid`  out  1  head entry will write a register.
- `fwd_reg`  out  REG_W  forwarding register index.
- `fwd_data`  out  DATA_W  forwarding data.
- `stall_count`  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Storage: main register (head) and skid register, each with its own valid bit.
- Definitions:
  - push = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
- States:
  - EMPTY: main and skid both invalid.
  - BUSY: main valid, skid invalid.
  - FULL: main and skid both valid.
- Transitions:
  - EMPTY: push → BUSY, main ← in.
  - BUSY, push & !pop → FULL, skid ← in.
  - BUSY, push & pop → BUSY, main ← in.
  - BUSY, !push & pop → EMPTY.
  - BUSY, neither → hold.
  - FULL: push is impossible. pop → BUSY, main ← skid. No pop → hold.
- `in_ready` is registered. It is 1 in every state except FULL; in FULL it is 0.
- `flush` has priority over push and pop:
  - Next state is EMPTY and both valid bits clear.
  - Any push in the same cycle is discarded.
  - Payload registers hold their values.
- Head payload gating: when `out_valid`=0, all `out_*` payload outputs read 0 (a bubble, with destination $zero).
- `fwd_valid` = `out_valid & (out_write_reg != 0) & (out_byteenable != 0)`.
  - `fwd_reg` and `fwd_data` equal the head payload when `fwd_valid`=1, and 0 otherwise.
- `stall_count` increments by 1 each cycle that `out_valid & !out_ready` holds.
  - It saturates at all-ones and does not wrap.
  - It is not cleared by `flush`; only reset clears it.
- Ordering: entries leave in strict arrival order. No entry is duplicated or dropped, except on flush.

## Timing
- Reset (asynchronous assert, release synchronous to `clock`):
  - State EMPTY, `in_ready`=1, `out_valid`=0.
  - All payload registers 0, all `out_*` and `fwd_*` outputs 0.
  - `stall_count`=0.
- Latency:
  - An entry pushed at edge N is visible on `out_*` after edge N, one cycle of latency.
  - Throughput is 1 entry per cycle while `out_ready`=1.
- `in_ready` falls in the cycle after the push that fills the skid. It rises in the cycle after the pop that drains the skid.
- No combinational path exists from `out_ready` to `in_ready`.
- Outputs depend only on registers. `fwd_*` is combinational from the head registers only.
- Flush asserted at edge N: `out_valid`=0 and `in_ready`=1 after edge N.
- Reset asserted mid-operation clears everything immediately, regardless of `clock`.

## Test plan
- **Reset:** release `reset` with `in_valid`=0. Expect `in_ready`=1, `out_valid`=0, all payload/fwd outputs 0, `stall_count`=0.
- **Streaming:** `out_ready`=1; push 4 entries back-to-back with `write_reg` 1..4 and data 0x11..0x44. Expect each on `out_*` one cycle later in order, and `in_ready` to stay 1.
- **Back-pressure:**
  - With `out_ready`=0, push A (reg 3, 0xAAAA0000) then B (reg 4, 0xBBBB0000). Expect `in_ready`=0 after B and `stall_count` to increment each cycle.
  - Raise `out_ready`. Expect A, then B, on consecutive cycles, then `in_ready`=1.
- **Flush in FULL:** fill as in the back-pressure test, then assert `flush` with `in_valid`=1. Expect `out_valid`=0 and `in_ready`=1 next cycle. The flushed input never appears at the output, and `stall_count` is retained.
- **Forwarding:**
  - Head reg 0 with be 0xF → `fwd_valid`=0.
  - Head reg 7 with be 0x0 → `fwd_valid`=0.
  - Head reg 7 with be 0x3 and data 0x1234 → `fwd_valid`=1, `fwd_reg`=7, `fwd_data`=0x1234.
- **Saturation:** set `CNT_W`=4 and hold `out_valid`=1, `out_ready`=0 for 20 cycles. Expect `stall_count` to stick at 15.

Source files
------------

// File: rtl/mem_stage_skid.sv
// EX->MEM pipeline stage register with a two-entry skid buffer.
// The head (main) register drives the memory stage; the skid register
// catches the one entry that can arrive while the head is back-pressured.
// Because in_ready is registered, out_ready never reaches in_ready
// combinationally. Also provides flush, forwarding taps and a saturating
// back-pressure counter.
module mem_stage_skid #(
   parameter int DATA_W = 32,
   parameter int BE_W   = DATA_W / 8,
   parameter int REG_W  = 5,
   parameter int OPC_W  = 6,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_W-1:0]  in_write_reg,
   input  logic [DATA_W-1:0] in_write_data,
   input  logic [BE_W-1:0]   in_byteenable,
   input  logic [OPC_W-1:0]  in_opcode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [REG_W-1:0]  out_write_reg,
   output logic [DATA_W-1:0] out_write_data,
   output logic [BE_W-1:0]   out_byteenable,
   output logic [OPC_W-1:0]  out_opcode,
   output logic              fwd_valid,
   output logic [REG_W-1:0]  fwd_reg,
   output logic [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]  stall_count
);

   typedef struct packed {
      logic [REG_W-1:0]  write_reg;
      logic [DATA_W-1:0] write_data;
      logic [BE_W-1:0]   byteenable;
      logic [OPC_W-1:0]  opcode;
   } entry_t;

   // EMPTY: nothing held; BUSY: head only; FULL: head and skid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_nxt;
   logic             in_ready_q;
   entry_t           main_q;
   entry_t           skid_q;
   entry_t           in_entry;
   logic             main_valid;
   logic             push;
   logic             pop;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;
   logic [CNT_W-1:0] stall_q;

   assign in_entry   = '{write_reg:  in_write_reg,
                         write_data: in_write_data,
                         byteenable: in_byteenable,
                         opcode:     in_opcode};
   assign main_valid = (state_q != ST_EMPTY);
   assign push       = in_valid & in_ready_q;
   assign pop        = main_valid & out_ready;
   assign in_ready   = in_ready_q;

   // State register plus the registered ready, derived from the next state
   // so that it depends only on what the stage will hold after this edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         // NOTE: sequential state always uses <= so every flop samples the
         // pre-edge values; blocking here would create order-dependent races.
         state_q    <= state_nxt;
         in_ready_q <= (state_nxt != ST_FULL);
      end
   end

   // Next-state and payload-load decisions; flush overrides everything.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_nxt      = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  state_nxt    = ST_BUSY;
                  load_main_in = 1'b1;
               end
            end
            ST_BUSY: begin
               if (push && !pop) begin
                  state_nxt = ST_FULL;
                  load_skid = 1'b1;
               end else if (push && pop) begin
                  load_main_in = 1'b1;
               end else if (pop) begin
                  state_nxt = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  state_nxt      = ST_BUSY;
                  load_main_skid = 1'b1;
               end
            end
            default: state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Payload registers; they keep their contents across a flush.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         // NOTE: the payload is reset explicitly so that a freshly reset stage
         // holds known zeros rather than X, even though valid bits gate it.
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in) begin
            main_q <= in_entry;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_entry;
         end
      end
   end

   // Back-pressure counter: counts stalled head cycles, sticks at all-ones.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (main_valid && !out_ready && (stall_q != '1)) begin
         stall_q <= stall_q + CNT_W'(1);
      end
   end

   assign stall_count = stall_q;

   // Output decode: head payload gated to a zero bubble when invalid, and
   // forwarding only for entries that really write a non-zero register.
   always_comb begin
      out_valid      = main_valid;
      out_write_reg  = '0;
      out_write_data = '0;
      out_byteenable = '0;
      out_opcode     = '0;
      fwd_valid      = 1'b0;
      fwd_reg        = '0;
      fwd_data       = '0;
      if (main_valid) begin
         out_write_reg  = main_q.write_reg;
         out_write_data = main_q.write_data;
         out_byteenable = main_q.byteenable;
         out_opcode     = main_q.opcode;
         if ((main_q.write_reg != '0) && (main_q.byteenable != '0)) begin
            fwd_valid = 1'b1;
            fwd_reg   = main_q.write_reg;
            fwd_data  = main_q.write_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_skid.sv
// Directed bench for mem_stage_skid: reset, streaming, back-pressure,
// flush in FULL, forwarding qualification and counter saturation (via a
// second instance with a 4-bit counter sharing the same stimulus).
module tb_mem_stage_skid;

   logic        clock;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic [4:0]  in_write_reg;
   logic [31:0] in_write_data;
   logic [3:0]  in_byteenable;
   logic [5:0]  in_opcode;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [4:0]  out_write_reg;
   logic [31:0] out_write_data;
   logic [3:0]  out_byteenable;
   logic [5:0]  out_opcode;
   logic        fwd_valid;
   logic [4:0]  fwd_reg;
   logic [31:0] fwd_data;
   logic [15:0] stall_count;

   logic        s_in_ready;
   logic        s_out_valid;
   logic [4:0]  s_out_write_reg;
   logic [31:0] s_out_write_data;
   logic [3:0]  s_out_byteenable;
   logic [5:0]  s_out_opcode;
   logic        s_fwd_valid;
   logic [4:0]  s_fwd_reg;
   logic [31:0] s_fwd_data;
   logic [3:0]  s_stall_count;

   int n_checks = 0;
   int n_pass   = 0;

   mem_stage_skid dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_write_reg(in_write_reg), .in_write_data(in_write_data),
      .in_byteenable(in_byteenable), .in_opcode(in_opcode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_write_reg(out_write_reg), .out_write_data(out_write_data),
      .out_byteenable(out_byteenable), .out_opcode(out_opcode),
      .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
      .stall_count(stall_count)
   );

   mem_stage_skid #(.CNT_W(4)) dut_sat (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(s_in_ready),
      .in_write_reg(in_write_reg), .in_write_data(in_write_data),
      .in_byteenable(in_byteenable), .in_opcode(in_opcode),
      .out_valid(s_out_valid), .out_ready(out_ready),
      .out_write_reg(s_out_write_reg), .out_write_data(s_out_write_data),
      .out_byteenable(s_out_byteenable), .out_opcode(s_out_opcode),
      .fwd_valid(s_fwd_valid), .fwd_reg(s_fwd_reg), .fwd_data(s_fwd_data),
      .stall_count(s_stall_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] observed,
                        input logic [63:0] expected);
      n_checks++;
      if (observed === expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d,
                        input logic [3:0] be, input logic [5:0] op);
      in_valid      = v;
      in_write_reg  = r;
      in_write_data = d;
      in_byteenable = be;
      in_opcode     = op;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"},  64'(in_ready), 64'd1);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_reg"},   64'(out_write_reg), 64'd0);
      check({tag, "_out_data"},  64'(out_write_data), 64'd0);
      check({tag, "_out_be"},    64'(out_byteenable), 64'd0);
      check({tag, "_out_opc"},   64'(out_opcode), 64'd0);
      check({tag, "_fwd_valid"}, 64'(fwd_valid), 64'd0);
      check({tag, "_fwd_reg"},   64'(fwd_reg), 64'd0);
      check({tag, "_fwd_data"},  64'(fwd_data), 64'd0);
   endtask

   initial begin
      reset     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 4'd0, 6'd0);

      // Reset
      step();
      step();
      check_idle("rst_held");
      check("rst_held_stall", 64'(stall_count), 64'd0);
      reset = 1'b1;
      step();
      check_idle("rst_rel");
      check("rst_rel_stall", 64'(stall_count), 64'd0);

      // Streaming: one entry per cycle, each visible after its push edge
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 5'(i), 32'(i * 32'h11), 4'hF, 6'(i));
         step();
         check($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("stream%0d_reg", i), 64'(out_write_reg), 64'(i));
         check($sformatf("stream%0d_data", i), 64'(out_write_data), 64'(i * 32'h11));
         check($sformatf("stream%0d_opc", i), 64'(out_opcode), 64'(i));
         check($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
      end
      drive(1'b0, 5'd0, 32'd0, 4'd0, 6'd0);
      step();
      check("stream_drain_valid", 64'(out_valid), 64'd0);
      check("stream_stall", 64'(stall_count), 64'd0);

      // Back-pressure: A into head, B into skid, ready drops
      out_ready = 1'b0;
      drive(1'b1, 5'd3, 32'hAAAA0000, 4'hF, 6'd1);
      step();
      check("bp_a_valid", 64'(out_valid), 64'd1);
      check("bp_a_reg", 64'(out_write_reg), 64'd3);
      check("bp_a_in_ready", 64'(in_ready), 64'd1);
      check("bp_a_stall", 64'(stall_count), 64'd0);
      drive(1'b1, 5'd4, 32'hBBBB0000, 4'hF, 6'd2);
      step();
      check("bp_b_in_ready", 64'(in_ready), 64'd0);
      check("bp_b_head_data", 64'(out_write_data), 64'hAAAA0000);
      check("bp_b_stall", 64'(stall_count), 64'd1);
      drive(1'b0, 5'd0, 32'd0, 4'd0, 6'd0);
      step();
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_head_data", 64'(out_write_data), 64'hAAAA0000);
      check("bp_hold_stall", 64'(stall_count), 64'd2);
      out_ready = 1'b1;
      step();
      check("bp_pop1_valid", 64'(out_valid), 64'd1);
      check("bp_pop1_reg", 64'(out_write_reg), 64'd4);
      check("bp_pop1_data", 64'(out_write_data), 64'hBBBB0000);
      check("bp_pop1_in_ready", 64'(in_ready), 64'd1);
      step();
      check("bp_pop2_valid", 64'(out_valid), 64'd0);
      check("bp_pop2_stall", 64'(stall_count), 64'd2);

      // Flush in FULL with a simultaneous push
      out_ready = 1'b0;
      drive(1'b1, 5'd5, 32'h55, 4'hF, 6'd3);
      step();
      drive(1'b1, 5'd6, 32'h66, 4'hF, 6'd4);
      step();
      check("fl_full_in_ready", 64'(in_ready), 64'd0);
      check("fl_full_stall", 64'(stall_count), 64'd3);
      flush = 1'b1;
      drive(1'b1, 5'd9, 32'h99, 4'hF, 6'd5);
      step();
      check("fl_out_valid", 64'(out_valid), 64'd0);
      check("fl_in_ready", 64'(in_ready), 64'd1);
      check("fl_out_reg", 64'(out_write_reg), 64'd0);
      check("fl_stall_kept", 64'(stall_count), 64'd4);
      flush = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 4'd0, 6'd0);
      step();
      check("fl_after_valid", 64'(out_valid), 64'd0);
      check("fl_after_stall", 64'(stall_count), 64'd4);

      // Forwarding qualification
      drive(1'b1, 5'd0, 32'hDEAD, 4'hF, 6'd6);
      step();
      check("fwd_r0_out_valid", 64'(out_valid), 64'd1);
      check("fwd_r0_valid", 64'(fwd_valid), 64'd0);
      check("fwd_r0_data", 64'(fwd_data), 64'd0);
      out_ready = 1'b1;
      drive(1'b1, 5'd7, 32'h5678, 4'h0, 6'd7);
      step();
      check("fwd_be0_reg", 64'(out_write_reg), 64'd7);
      check("fwd_be0_valid", 64'(fwd_valid), 64'd0);
      check("fwd_be0_reg_gated", 64'(fwd_reg), 64'd0);
      drive(1'b1, 5'd7, 32'h1234, 4'h3, 6'd8);
      step();
      check("fwd_ok_valid", 64'(fwd_valid), 64'd1);
      check("fwd_ok_reg", 64'(fwd_reg), 64'd7);
      check("fwd_ok_data", 64'(fwd_data), 64'h1234);
      check("fwd_ok_be", 64'(out_byteenable), 64'h3);
      drive(1'b0, 5'd0, 32'd0, 4'd0, 6'd0);
      step();
      check("fwd_drain_valid", 64'(out_valid), 64'd0);
      check("fwd_stall", 64'(stall_count), 64'd4);
      check("sat_pre", 64'(s_stall_count), 64'd4);

      // Saturation: hold a stalled head for 20 cycles
      out_ready = 1'b0;
      drive(1'b1, 5'd1, 32'h1, 4'h1, 6'd1);
      step();
      drive(1'b0, 5'd0, 32'd0, 4'd0, 6'd0);
      for (int k = 1; k <= 20; k++) begin
         step();
         check($sformatf("sat_small_%0d", k), 64'(s_stall_count),
               64'(((4 + k) > 15) ? 15 : (4 + k)));
         check($sformatf("sat_wide_%0d", k), 64'(stall_count), 64'(4 + k));
      end

      // Asynchronous reset mid-operation, away from any clock edge
      #2;
      reset = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_in_ready", 64'(in_ready), 64'd1);
      check("arst_stall", 64'(stall_count), 64'd0);
      check("arst_out_reg", 64'(out_write_reg), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
